fq_ingress: RTL and testbench

FQ_INGRESS -- requirements
Module: fq_ingress

---
 rtl/fq_ingress.sv | 153 +++++++++++++++
 tb/tb_fq_ingress.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fq_ingress.sv
// Write side of the fair-queue FIFOs: routes each packet of one input stream, whole,
// to the per-flow FIFO named in its header, dropping packets whose FIFO is full.
module fq_ingress #(
   parameter int NQ = 8,
   parameter int DW = 64,
   parameter int CW = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DW-1:0]          in_data,
   output logic [NQ-1:0]          fifo_wrreq,
   output logic [NQ-1:0][DW-1:0]  fifo_data,
   input  logic [NQ-1:0]          fifo_full,
   output logic [NQ-1:0][CW-1:0]  drop_cnt,
   output logic [CW-1:0]          err_cnt,
   output logic                   busy
);

   localparam int QW = $clog2(NQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [QW-1:0]   cur_q_r;
   logic [QW-1:0]   next_cur_q_s;
   logic [7:0]      remaining_r;
   logic [7:0]      next_rem_s;
   logic [NQ-1:0]   wrreq_r;
   logic [QW-1:0]   hdr_q_s;
   logic [7:0]      hdr_len_s;
   logic [QW-1:0]   wr_q_s;
   logic            ready_s;
   logic            accept_s;
   logic            fwd_s;
   logic            drop_inc_s;
   logic            err_inc_s;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CW-1){1'b0}}, 1'b1};
      end
   endfunction

   assign hdr_q_s   = in_data[DW-1 -: QW];
   assign hdr_len_s = in_data[7:0];

   // Readiness is a function of state, cur_q and fifo_full only
   always_comb begin
      ready_s = 1'b0;
      case (state_r)
         IDLE:    ready_s = 1'b1;
         FWD:     ready_s = ~fifo_full[cur_q_r];
         DROP:    ready_s = 1'b1;
         default: ready_s = 1'b0;
      endcase
   end

   assign in_ready = ready_s & ~rst;
   assign accept_s = in_valid & in_ready;

   // Next-state and per-word action decode
   always_comb begin
      next_state_s = state_r;
      next_cur_q_s = cur_q_r;
      next_rem_s   = remaining_r;
      wr_q_s       = cur_q_r;
      fwd_s        = 1'b0;
      drop_inc_s   = 1'b0;
      err_inc_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (hdr_len_s == 8'd0) begin
                  err_inc_s = 1'b1;
               end else begin
                  next_rem_s = hdr_len_s - 8'd1;
                  // Drop decision is taken here once and never revisited mid-packet
                  if (fifo_full[hdr_q_s]) begin
                     drop_inc_s   = 1'b1;
                     next_state_s = (hdr_len_s == 8'd1) ? IDLE : DROP;
                  end else begin
                     fwd_s        = 1'b1;
                     wr_q_s       = hdr_q_s;
                     next_cur_q_s = hdr_q_s;
                     next_state_s = (hdr_len_s == 8'd1) ? IDLE : FWD;
                  end
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         FWD: begin
            if (accept_s) begin
               fwd_s        = 1'b1;
               next_rem_s   = remaining_r - 8'd1;
               next_state_s = (remaining_r <= 8'd1) ? IDLE : FWD;
            end else begin
               next_state_s = FWD;
            end
         end
         DROP: begin
            if (accept_s) begin
               next_rem_s   = remaining_r - 8'd1;
               next_state_s = (remaining_r <= 8'd1) ? IDLE : DROP;
            end else begin
               next_state_s = DROP;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, write pipeline and statistics registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cur_q_r     <= '0;
         remaining_r <= 8'd0;
         wrreq_r     <= '0;
         fifo_data   <= '0;
         drop_cnt    <= '0;
         err_cnt     <= '0;
      end else begin
         state_r     <= next_state_s;
         cur_q_r     <= next_cur_q_s;
         remaining_r <= next_rem_s;
         wrreq_r     <= fwd_s ? ({{(NQ-1){1'b0}}, 1'b1} << wr_q_s) : '0;
         if (fwd_s) begin
            fifo_data[wr_q_s] <= in_data;
         end
         if (drop_inc_s) begin
            drop_cnt[hdr_q_s] <= sat_inc(drop_cnt[hdr_q_s]);
         end
         if (err_inc_s) begin
            err_cnt <= sat_inc(err_cnt);
         end
      end
   end

   // A write registered just before reset must not reach the FIFO while reset is held
   assign fifo_wrreq = wrreq_r & {NQ{~rst}};
   assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_fq_ingress.sv
// Directed bench for fq_ingress: a per-cycle vector table plus hand-written
// sequences for reset mid-packet and counter saturation.
module tb_fq_ingress;

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [63:0]         in_data;
   logic [7:0]          fifo_wrreq;
   logic [7:0][63:0]    fifo_data;
   logic [7:0]          fifo_full;
   logic [7:0][15:0]    drop_cnt;
   logic [15:0]         err_cnt;
   logic                busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic             valid;
      logic [63:0]      data;
      logic [7:0]       full;
      logic             e_ready;
      logic [7:0]       e_wrreq;
      logic [63:0]      e_data;
      logic             e_busy;
      logic [15:0]      e_err;
      logic [7:0][15:0] e_drop;
   } vec_t;

   vec_t             tbl[$];
   logic [15:0]      cur_err;
   logic [7:0][15:0] cur_drop;

   fq_ingress #(.NQ(8), .DW(64), .CW(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .fifo_wrreq (fifo_wrreq),
      .fifo_data  (fifo_data),
      .fifo_full  (fifo_full),
      .drop_cnt   (drop_cnt),
      .err_cnt    (err_cnt),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] hdr(input logic [2:0] q, input logic [7:0] len,
                                       input logic [52:0] tag);
      return {q, tag, len};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [63:0] d, input logic [7:0] f,
                      input logic er, input logic [7:0] ew, input logic [63:0] ed,
                      input logic eb);
      vec_t r;
      r.valid = v;  r.data = d;  r.full = f;
      r.e_ready = er;  r.e_wrreq = ew;  r.e_data = ed;  r.e_busy = eb;
      r.e_err = cur_err;  r.e_drop = cur_drop;
      tbl.push_back(r);
   endtask

   initial begin
      logic [63:0] h3, h5a, h5b, h2, hz, h01, h6, h4, h1, h7, h31;
      int idx;

      h3  = hdr(3'd3, 8'd4, 53'h1A5A5);
      h5a = hdr(3'd5, 8'd3, 53'h0F0F);
      h5b = hdr(3'd5, 8'd1, 53'h1234_5678);
      h2  = hdr(3'd2, 8'd6, 53'h0BEEF);
      hz  = hdr(3'd0, 8'd0, 53'h7);
      h01 = hdr(3'd0, 8'd1, 53'h1F_FFFF_FFFF_FFFF);
      h6  = hdr(3'd6, 8'd1, 53'h00C0FFEE);
      h4  = hdr(3'd4, 8'd2, 53'h44);
      h1  = hdr(3'd1, 8'd1, 53'h11);
      h7  = hdr(3'd7, 8'd5, 53'h77);
      h31 = hdr(3'd3, 8'd1, 53'h333);
      cur_err  = 16'd0;
      cur_drop = '0;

      // q=3 len=4, continuous, all FIFOs empty
      add(1'b1, h3,             8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      add(1'b1, 64'hA1,         8'h00, 1'b1, 8'h08, h3,             1'b1);
      add(1'b1, 64'hA2,         8'h00, 1'b1, 8'h08, 64'hA1,         1'b1);
      add(1'b1, 64'hA3,         8'h00, 1'b1, 8'h08, 64'hA2,         1'b1);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h08, 64'hA3,         1'b0);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      // q=5 len=3 arrives with FIFO 5 full -> dropped, then a normal q=5 packet
      add(1'b1, h5a,            8'h20, 1'b1, 8'h00, 64'h0,          1'b0);
      cur_drop[5] = 16'd1;
      add(1'b1, 64'hB1,         8'h20, 1'b1, 8'h00, 64'h0,          1'b1);
      add(1'b1, 64'hB2,         8'h20, 1'b1, 8'h00, 64'h0,          1'b1);
      add(1'b1, h5b,            8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h20, h5b,            1'b0);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      // q=2 len=6, FIFO 2 goes full for 4 cycles mid-packet -> stall, no drop
      add(1'b1, h2,             8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      add(1'b1, 64'hC1,         8'h00, 1'b1, 8'h04, h2,             1'b1);
      add(1'b1, 64'hC2,         8'h04, 1'b0, 8'h04, 64'hC1,         1'b1);
      add(1'b1, 64'hC2,         8'h04, 1'b0, 8'h00, 64'h0,          1'b1);
      add(1'b1, 64'hC2,         8'h04, 1'b0, 8'h00, 64'h0,          1'b1);
      add(1'b1, 64'hC2,         8'h04, 1'b0, 8'h00, 64'h0,          1'b1);
      add(1'b1, 64'hC2,         8'h00, 1'b1, 8'h00, 64'h0,          1'b1);
      add(1'b1, 64'hC3,         8'h00, 1'b1, 8'h04, 64'hC2,         1'b1);
      add(1'b1, 64'hC4,         8'h00, 1'b1, 8'h04, 64'hC3,         1'b1);
      add(1'b1, 64'hC5,         8'h00, 1'b1, 8'h04, 64'hC4,         1'b1);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h04, 64'hC5,         1'b0);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      // len=0 header is an error, then a single-word packet to q=0
      add(1'b1, hz,             8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      cur_err = 16'd1;
      add(1'b1, h01,            8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h01, h01,            1'b0);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h00, 64'h0,          1'b0);
      // back-to-back packets; other FIFOs full do not affect q=6
      add(1'b1, h6,             8'hBF, 1'b1, 8'h00, 64'h0,          1'b0);
      add(1'b1, h4,             8'h00, 1'b1, 8'h40, h6,             1'b0);
      add(1'b1, 64'hE1,         8'h00, 1'b1, 8'h10, h4,             1'b1);
      add(1'b1, h1,             8'h00, 1'b1, 8'h10, 64'hE1,         1'b0);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h02, h1,             1'b0);
      add(1'b0, 64'h0,          8'h00, 1'b1, 8'h00, 64'h0,          1'b0);

      // reset state
      rst = 1'b1;  in_valid = 1'b1;  in_data = h01;  fifo_full = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_wrreq", fifo_wrreq, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err_cnt, 16'd0);
      chk("rst_drop", drop_cnt, 128'd0);
      chk("rst_data", fifo_data == '0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;  in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1'b1);
      chk("post_rst_wrreq", fifo_wrreq, 8'h00);

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         in_valid  = tbl[i].valid;
         in_data   = tbl[i].data;
         fifo_full = tbl[i].full;
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), in_ready, tbl[i].e_ready);
         chk($sformatf("v%0d_wrreq", i), fifo_wrreq, tbl[i].e_wrreq);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("v%0d_err", i), err_cnt, tbl[i].e_err);
         chk($sformatf("v%0d_drop", i), drop_cnt, tbl[i].e_drop);
         if (tbl[i].e_wrreq != 8'h00) begin
            idx = 0;
            for (int k = 0; k < 8; k++) begin
               if (tbl[i].e_wrreq[k]) idx = k;
            end
            chk($sformatf("v%0d_data", i), fifo_data[idx], tbl[i].e_data);
         end
      end

      // reset on word 2 of a len=5 packet to q=7
      @(posedge clk); #1;
      in_valid = 1'b1;  in_data = h7;  fifo_full = 8'h00;
      @(negedge clk);
      chk("r7_hdr_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_data = 64'h71;
      @(negedge clk);
      chk("r7_w0_wrreq", fifo_wrreq, 8'h80);
      chk("r7_w0_data", fifo_data[7], h7);
      @(posedge clk); #1;
      in_data = 64'h72;  rst = 1'b1;
      @(negedge clk);
      chk("r7_rst_ready", in_ready, 1'b0);
      chk("r7_rst_wrreq", fifo_wrreq, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;  in_data = h31;
      @(negedge clk);
      chk("r7_after_ready", in_ready, 1'b1);
      chk("r7_after_wrreq", fifo_wrreq, 8'h00);
      chk("r7_after_busy", busy, 1'b0);
      chk("r7_after_err", err_cnt, 16'd0);
      chk("r7_after_drop", drop_cnt, 128'd0);
      chk("r7_after_data", fifo_data == '0, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("r7_newhdr_wrreq", fifo_wrreq, 8'h08);
      chk("r7_newhdr_data", fifo_data[3], h31);
      chk("r7_newhdr_busy", busy, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("r7_idle_wrreq", fifo_wrreq, 8'h00);

      // drop_cnt[1] saturation via a stream of dropped single-word packets
      @(posedge clk); #1;
      in_valid = 1'b1;  in_data = h1;  fifo_full = 8'h02;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      chk("sat_fffe", drop_cnt[1], 16'hFFFE);
      @(posedge clk);
      @(negedge clk);
      chk("sat_ffff", drop_cnt[1], 16'hFFFF);
      chk("sat_wrreq", fifo_wrreq, 8'h00);
      @(posedge clk);
      @(negedge clk);
      chk("sat_hold", drop_cnt[1], 16'hFFFF);
      chk("sat_others", drop_cnt[0], 16'd0);
      chk("sat_busy", busy, 1'b0);
      in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
